// File: rtl/uart_rx_vaaman.sv
// UART receiver: 2-FF synchronised input, mid-bit sampling, optional parity; strobes one cycle after the stop sample.
// No backpressure: o_rx_valid/o_parity_err/o_frame_err are single-cycle strobes that the consumer must catch.
module uart_rx_vaaman #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy,
    output logic                 o_led
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST    = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state, state_n;
    logic                 rx_m, rx_s, rx_prev;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_err, par_err_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n, perr_n, ferr_n, led_n;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_m         <= 1'b1;
            rx_s         <= 1'b1;
            rx_prev      <= 1'b1;
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            par_err      <= 1'b0;
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_led        <= 1'b0;
        end else begin
            rx_m         <= i_rx;
            rx_s         <= rx_m;
            rx_prev      <= rx_s;
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= bit_n;
            shreg        <= shreg_n;
            par_err      <= par_err_n;
            o_rx_data    <= data_n;
            o_rx_valid   <= valid_n;
            o_parity_err <= perr_n;
            o_frame_err  <= ferr_n;
            o_led        <= led_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        bit_n     = bit_idx;
        shreg_n   = shreg;
        par_err_n = par_err;
        data_n    = o_rx_data;
        valid_n   = 1'b0;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        led_n     = o_led;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                // Needs a high-to-low transition, so a held-low break never starts a frame.
                if (rx_prev && !rx_s) state_n = S_START;
            end
            S_START: begin
                if (cnt == HALF_M1) begin
                    cnt_n     = '0;
                    bit_n     = '0;
                    par_err_n = 1'b0;
                    state_n   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_idx == LAST) state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    else                 bit_n   = bit_idx + BW'(1);
                end
            end
            S_PARITY: begin
                if (cnt == BIT_M1) begin
                    cnt_n     = '0;
                    par_err_n = (^shreg) ^ rx_s ^ (PARITY == 1);
                    state_n   = S_STOP;
                end
            end
            S_STOP: begin
                // Return to IDLE mid-stop-bit so a following start edge is not missed.
                if (cnt == BIT_M1) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                    if (rx_s) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        perr_n  = par_err;
                        led_n   = o_led ^ ~par_err;
                    end else begin
                        ferr_n  = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign o_busy = (state != S_IDLE);
endmodule
